// File: rtl/uart_tx_fifo_engine.sv
// UART transmit path: byte FIFO drained by a start/data/parity/stop serializer.
// Bit timing comes from a shared 16x baud tick.
module uart_tx_fifo_engine #(
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       fifoWe,
  input  logic [7:0]                 dataIn,
  input  logic                       fifoClear,
  input  logic                       baudTickX16,
  input  logic [1:0]                 nrOfDataBits,
  input  logic                       parityEnable,
  input  logic                       evenParity,
  input  logic                       stickParity,
  input  logic                       twoStopBits,
  input  logic                       sendBreak,
  output logic                       fifoFull,
  output logic                       fifoEmpty,
  output logic [FIFO_DEPTH_LOG2:0]   nrOfEntries,
  output logic                       writeError,
  output logic                       busy,
  output logic                       txd
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_CNT = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  logic [7:0]                 r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wrPtr;
  logic [FIFO_DEPTH_LOG2-1:0] r_rdPtr;
  logic [FIFO_DEPTH_LOG2:0]   r_count;
  logic [FIFO_DEPTH_LOG2:0]   w_countNext;
  logic                       r_full;
  logic                       r_empty;
  logic                       r_writeError;
  logic                       w_push;
  logic                       w_pop;

  state_t                     r_state;
  state_t                     w_stateNext;
  logic [3:0]                 r_tickCnt;
  logic [2:0]                 r_bitCnt;
  logic [7:0]                 r_shift;
  logic [1:0]                 r_nBits;
  logic                       r_parEn;
  logic                       r_twoStop;
  logic                       r_parityBit;
  logic                       r_txd;

  logic                       w_bitEnd;
  logic                       w_txdNext;
  logic [7:0]                 w_head;
  logic [7:0]                 w_headMask;
  logic                       w_headParity;
  logic [2:0]                 w_lastBit;

  assign w_head    = r_mem[r_rdPtr];
  // A write into a full FIFO still lands when the serializer pops in the same cycle.
  assign w_push    = fifoWe & (~r_full | w_pop);
  assign w_bitEnd  = baudTickX16 && (r_tickCnt == 4'd15);
  assign w_lastBit = 3'd4 + {1'b0, r_nBits};

  always_comb begin
    w_countNext = r_count;
    case ({w_push, w_pop})
      2'b10:   w_countNext = r_count + 1'b1;
      2'b01:   w_countNext = r_count - 1'b1;
      default: w_countNext = r_count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_push && !fifoClear) begin
      r_mem[r_wrPtr] <= dataIn;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_writeError <= 1'b0;
    end else begin
      r_writeError <= fifoWe & r_full & ~w_pop & ~fifoClear;
      if (fifoClear) begin
        r_wrPtr <= '0;
        r_rdPtr <= '0;
        r_count <= '0;
        r_full  <= 1'b0;
        r_empty <= 1'b1;
      end else begin
        if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
        if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
        r_count <= w_countNext;
        r_full  <= (w_countNext == FULL_CNT);
        r_empty <= (w_countNext == '0);
      end
    end
  end

  always_comb begin
    w_headMask = 8'hFF;
    case (nrOfDataBits)
      2'b00:   w_headMask = 8'h1F;
      2'b01:   w_headMask = 8'h3F;
      2'b10:   w_headMask = 8'h7F;
      default: w_headMask = 8'hFF;
    endcase
  end

  assign w_headParity = stickParity ? ~evenParity
                                    : (^(w_head & w_headMask)) ^ ~evenParity;

  always_comb begin
    w_stateNext = r_state;
    w_pop       = 1'b0;
    w_txdNext   = 1'b1;
    case (r_state)
      IDLE: begin
        if (!r_empty) begin
          w_pop       = 1'b1;
          w_stateNext = START;
        end
      end
      START: begin
        w_txdNext = 1'b0;
        if (w_bitEnd) w_stateNext = DATA;
      end
      DATA: begin
        w_txdNext = r_shift[0];
        if (w_bitEnd && (r_bitCnt == w_lastBit)) begin
          w_stateNext = r_parEn ? PARITY : STOP1;
        end
      end
      PARITY: begin
        w_txdNext = r_parityBit;
        if (w_bitEnd) w_stateNext = STOP1;
      end
      STOP1: begin
        if (w_bitEnd) begin
          if (r_twoStop) begin
            w_stateNext = STOP2;
          end else if (!r_empty) begin
            w_pop       = 1'b1;
            w_stateNext = START;
          end else begin
            w_stateNext = IDLE;
          end
        end
      end
      STOP2: begin
        if (w_bitEnd) begin
          if (!r_empty) begin
            w_pop       = 1'b1;
            w_stateNext = START;
          end else begin
            w_stateNext = IDLE;
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // txd is registered from the current state, so it trails the state by one cycle
  // uniformly; every bit therefore still spans exactly 16 ticks.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tickCnt   <= '0;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_nBits     <= '0;
      r_parEn     <= 1'b0;
      r_twoStop   <= 1'b0;
      r_parityBit <= 1'b0;
      r_txd       <= 1'b1;
    end else begin
      r_txd <= w_txdNext;
      if (w_pop) begin
        r_shift     <= w_head;
        r_nBits     <= nrOfDataBits;
        r_parEn     <= parityEnable;
        r_twoStop   <= twoStopBits;
        r_parityBit <= w_headParity;
        r_tickCnt   <= '0;
        r_bitCnt    <= '0;
      end else if ((r_state != IDLE) && baudTickX16) begin
        r_tickCnt <= r_tickCnt + 1'b1;
        if ((r_state == DATA) && w_bitEnd) begin
          r_shift  <= r_shift >> 1;
          r_bitCnt <= r_bitCnt + 1'b1;
        end
      end
    end
  end

  assign fifoFull    = r_full;
  assign fifoEmpty   = r_empty;
  assign nrOfEntries = r_count;
  assign writeError  = r_writeError;
  assign busy        = ~r_empty | (r_state != IDLE);
  assign txd         = r_txd & ~sendBreak;

endmodule
